// File: rtl/clock_rst_seq.sv
// PLL-lock qualified, staggered reset sequencer for the clk_sys domain.
// Optional lock-loss counter enabled by defining CLOCK_RST_SEQ_LOSS_CNT_EN.
module clock_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 16,
  parameter int NUM_RST     = 3,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               soft_rst,
  input  logic               sticky_clr,
  output logic [NUM_RST-1:0] rst_out,
  output logic               all_released,
  output logic               unlock_sticky,
  output logic [CNT_W-1:0]   loss_cnt
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clock_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (LOCK_HOLD < 1) begin : g_bad_hold
    $error("clock_rst_seq: LOCK_HOLD must be >= 1");
  end
  if (NUM_RST < 1) begin : g_bad_num
    $error("clock_rst_seq: NUM_RST must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("clock_rst_seq: STAGGER must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("clock_rst_seq: CNT_W must be >= 1");
  end

  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam int STAG_W = $clog2(STAGGER + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] RELEASE   = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [1:0]             state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [STAG_W-1:0]      stag_cnt;
  logic [NUM_RST-1:0]     rst_next;
  logic                   active;
  logic                   lock_loss;
  logic                   abort;

  assign lock_s = sync[SYNC_STAGES-1];

  // Bits release LSB-first, so the next pattern is simply the current one
  // shifted up; an all-zero result means this release is the last one.
  always_comb begin
    rst_next  = rst_out << 1;
    active    = (state == RELEASE) || (state == RUN);
    lock_loss = active && !lock_s;
    abort     = active && (!lock_s || soft_rst);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync         <= '0;
      state        <= WAIT_LOCK;
      hold_cnt     <= '0;
      stag_cnt     <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_lock};
      if (abort) begin
        state        <= WAIT_LOCK;
        hold_cnt     <= '0;
        stag_cnt     <= '0;
        rst_out      <= '1;
        all_released <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            rst_out      <= '1;
            all_released <= 1'b0;
            stag_cnt     <= '0;
            if (!lock_s || soft_rst) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              rst_out  <= rst_next;
              if (rst_next == '0) begin
                state        <= RUN;
                all_released <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          RELEASE: begin
            if (stag_cnt == STAG_LAST) begin
              stag_cnt <= '0;
              rst_out  <= rst_next;
              if (rst_next == '0) begin
                state        <= RUN;
                all_released <= 1'b1;
              end
            end else begin
              stag_cnt <= stag_cnt + STAG_W'(1);
            end
          end
          RUN: begin
            all_released <= 1'b1;
          end
          default: begin
            state        <= WAIT_LOCK;
            hold_cnt     <= '0;
            stag_cnt     <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
          end
        endcase
      end
    end
  end

  // A fresh lock loss outranks a clear in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      unlock_sticky <= 1'b0;
    end else if (lock_loss) begin
      unlock_sticky <= 1'b1;
    end else if (sticky_clr) begin
      unlock_sticky <= 1'b0;
    end
  end

`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (lock_loss && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + CNT_W'(1);
    end
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clock_rst_seq.sv
// Directed bench for clock_rst_seq: default instance plus a CNT_W=2,
// NUM_RST=1, LOCK_HOLD=1 instance for saturation and single-output release.
module tb_clock_rst_seq;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst;
  logic       sticky_clr;
  logic [2:0] rst_out;
  logic       all_released;
  logic       unlock_sticky;
  logic [7:0] loss_cnt;

  logic       pll_lock2;
  logic [0:0] rst_out2;
  logic       all_rel2;
  logic       sticky2;
  logic [1:0] loss2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk_sys = ~clk_sys;

  clock_rst_seq dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .soft_rst     (soft_rst),
    .sticky_clr   (sticky_clr),
    .rst_out      (rst_out),
    .all_released (all_released),
    .unlock_sticky(unlock_sticky),
    .loss_cnt     (loss_cnt)
  );

  clock_rst_seq #(
    .SYNC_STAGES(2),
    .LOCK_HOLD  (1),
    .NUM_RST    (1),
    .STAGGER    (2),
    .CNT_W      (2)
  ) dut2 (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pll_lock     (pll_lock2),
    .soft_rst     (1'b0),
    .sticky_clr   (1'b0),
    .rst_out      (rst_out2),
    .all_released (all_rel2),
    .unlock_sticky(sticky2),
    .loss_cnt     (loss2)
  );

  typedef struct {
    int         at;
    logic       lock;
    logic [2:0] exp_rst;
    logic       exp_all;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_loss(input int n, input int maxv);
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
    return (n < maxv) ? n : maxv;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int r;
    vt[0] = '{at: 2,  lock: 1'b1, exp_rst: 3'b111, exp_all: 1'b0};
    vt[1] = '{at: 17, lock: 1'b1, exp_rst: 3'b111, exp_all: 1'b0};
    vt[2] = '{at: 18, lock: 1'b1, exp_rst: 3'b110, exp_all: 1'b0};
    vt[3] = '{at: 21, lock: 1'b1, exp_rst: 3'b110, exp_all: 1'b0};
    vt[4] = '{at: 22, lock: 1'b1, exp_rst: 3'b100, exp_all: 1'b0};
    vt[5] = '{at: 25, lock: 1'b1, exp_rst: 3'b100, exp_all: 1'b0};
    vt[6] = '{at: 26, lock: 1'b1, exp_rst: 3'b000, exp_all: 1'b1};
    vt[7] = '{at: 30, lock: 1'b1, exp_rst: 3'b000, exp_all: 1'b1};

    rst = 1'b1; pll_lock = 1'b0; soft_rst = 1'b0; sticky_clr = 1'b0; pll_lock2 = 1'b0;
    ticks(3);
    check("reset_rst_out", 32'(rst_out), 32'h7);
    check("reset_all_rel", 32'(all_released), 0);
    check("reset_sticky", 32'(unlock_sticky), 0);
    check("reset_loss", 32'(loss_cnt), 0);
    check("reset_rst_out2", 32'(rst_out2), 1);
    rst = 1'b0;
    cyc = 0;

    // Steady lock from cycle 0: staggered release
    for (int i = 0; i < 8; i++) begin
      pll_lock = vt[i].lock;
      while (cyc < vt[i].at) tick();
      check("seq_rst_out", 32'(rst_out), 32'(vt[i].exp_rst));
      check("seq_all_rel", 32'(all_released), 32'(vt[i].exp_all));
    end

    // Lock loss in RUN: abort SYNC_STAGES+1 edges after the fall
    pll_lock = 1'b0;
    ticks(2);
    check("loss_pre_rst_out", 32'(rst_out), 0);
    check("loss_pre_all_rel", 32'(all_released), 1);
    tick();
    check("loss_rst_out", 32'(rst_out), 32'h7);
    check("loss_all_rel", 32'(all_released), 0);
    check("loss_sticky", 32'(unlock_sticky), 1);
    check("loss_cnt1", 32'(loss_cnt), exp_loss(1, 255));

    // Lock glitch during hold restarts the count
    do_reset();
    pll_lock = 1'b1;
    ticks(10);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    r = cyc;
    ticks(8);
    check("glitch_no_early", 32'(rst_out), 32'h7);
    while (cyc < r + 17) tick();
    check("glitch_pre_rel", 32'(rst_out), 32'h7);
    tick();
    check("glitch_rel0", 32'(rst_out), 32'h6);
    check("glitch_sticky", 32'(unlock_sticky), 0);
    check("glitch_loss", 32'(loss_cnt), 0);

    // soft_rst two cycles into RELEASE
    ticks(2);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("soft_rst_out", 32'(rst_out), 32'h7);
    check("soft_sticky", 32'(unlock_sticky), 0);
    r = cyc;
    ticks(15);
    check("soft_pre_rel", 32'(rst_out), 32'h7);
    tick();
    check("soft_rel0", 32'(rst_out), 32'h6);
    check("soft_loss", 32'(loss_cnt), 0);

    // sticky_clr coincident with a lock loss: set wins
    pll_lock = 1'b0;
    ticks(2);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("clr_race_rst_out", 32'(rst_out), 32'h7);
    check("clr_race_sticky", 32'(unlock_sticky), 1);
    check("clr_race_loss", 32'(loss_cnt), exp_loss(1, 255));
    tick();
    check("sticky_hold", 32'(unlock_sticky), 1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared", 32'(unlock_sticky), 0);

    // Second instance: single output, immediate release, saturating counter
    do_reset();
    pll_lock = 1'b0;
    pll_lock2 = 1'b1;
    ticks(2);
    check("n1_pre_rel", 32'(rst_out2), 1);
    tick();
    check("n1_rel", 32'(rst_out2), 0);
    check("n1_all_rel", 32'(all_rel2), 1);
    for (int k = 1; k <= 4; k++) begin
      pll_lock2 = 1'b0;
      ticks(3);
      check("sat_rst_out", 32'(rst_out2), 1);
      check("sat_loss", 32'(loss2), exp_loss(k, 3));
      pll_lock2 = 1'b1;
      ticks(3);
      check("sat_rerel", 32'(rst_out2), 0);
    end
    check("sat_sticky", 32'(sticky2), 1);

    // rst overrides everything mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ovr_rst_out2", 32'(rst_out2), 1);
    check("rst_ovr_all_rel2", 32'(all_rel2), 0);
    check("rst_ovr_sticky2", 32'(sticky2), 0);
    check("rst_ovr_loss2", 32'(loss2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
